stage_memory: RTL and testbench

STAGE_MEMORY -- requirements
Module: stage_memory

---
 rtl/rv32i_types.sv | 39 +++
 rtl/stage_memory_load_align.sv | 23 ++
 rtl/stage_memory.sv | 128 ++++++++++++
 tb/tb_stage_memory.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the memory stage.
//   mem_state_t        : IDLE / ACCESS / DONE handshake states
//   load/store funct3  : RV32I width encodings
//   rv32i_control_word : control bits the memory stage consumes
//   byte_mask          : lane enables for a width code and byte offset, truncated to the word
package rv32i_types;

    localparam int MAX_WAIT_DEFAULT = 255;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } rv32i_control_word;

    // Loads use the same width code in bits [1:0], so one mask serves both directions.
    function automatic logic [3:0] byte_mask(input logic [1:0] sz, input logic [1:0] off);
        logic [2:0] k;
        k = {1'b0, sz};
        byte_mask = k == SW ? 4'b1111 : k == SH ? 4'b0011 << off : 4'b0001 << off;
    endfunction

endpackage

// File: rtl/stage_memory_load_align.sv
// load_align: picks the addressed byte/halfword out of a read word and extends it.
//   rdata     : raw 32-bit word from data memory
//   off       : byte offset within the word
//   funct3    : load width/sign code
//   load_data : right-aligned, sign- or zero-extended result
module load_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted   = rdata >> {off, 3'b000};
    assign load_data = funct3 == LB  ? {{24{shifted[7]}}, shifted[7:0]}   :
                       funct3 == LH  ? {{16{shifted[15]}}, shifted[15:0]} :
                       funct3 == LBU ? {24'b0, shifted[7:0]}              :
                       funct3 == LHU ? {16'b0, shifted[15:0]}             : rdata;

endmodule

// File: rtl/stage_memory.sv
// stage_memory: RV32I memory stage with a request/response data-memory handshake.
//   clk, rst (sync, active low)         : clock and reset
//   ex_valid, ctrl, alu_out_ex_mem      : EX/MEM op, control word, byte address
//   rs2_fwd                             : store data
//   dmem_resp, dmem_rdata               : memory completion and read word
//   dmem_read/write/address/wdata/mbe   : registered memory request
//   mem_stall                           : freezes upstream while an access is in flight
//   load_data, load_valid               : aligned load result, valid in DONE
//   dmem_timeout                        : sticky flag, set when MAX_WAIT ACCESS cycles pass unanswered
//   misaligned                          : exists only with DMEM_MISALIGN_TRAP_EN; pulses on a trapped access
module stage_memory
    import rv32i_types::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  rv32i_control_word ctrl,
    input  logic [31:0]       alu_out_ex_mem,
    input  logic [31:0]       rs2_fwd,
    input  logic              dmem_resp,
    input  logic [31:0]       dmem_rdata,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [31:0]       dmem_address,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_mbe,
    output logic              mem_stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              dmem_timeout
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic              misaligned
`endif
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    mem_state_t  state_q;
    logic        read_q, write_q, timeout_q;
    logic [31:0] addr_q, wdata_q, load_data_q;
    logic [3:0]  mbe_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  off;
    logic        accept, trap;
    logic [31:0] aligned;

    assign off    = alu_out_ex_mem[1:0];
    assign accept = state_q == IDLE && ex_valid && (ctrl.mem_read || ctrl.mem_write);
    assign cnt_d  = cnt_q + 1'b1;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap       = accept && ((ctrl.funct3[1:0] == 2'b01 && off[0]) || (ctrl.funct3[1:0] == 2'b10 && off != 2'b00));
    assign misaligned = trap && rst;
`else
    assign trap = 1'b0;
`endif

    // A trapped access completes without stalling; reset also releases the pipeline.
    assign mem_stall    = rst && ((accept && !trap) || state_q == ACCESS);
    assign load_valid   = state_q == DONE;
    assign dmem_read    = read_q;
    assign dmem_write   = write_q;
    assign dmem_address = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_mbe     = mbe_q;
    assign load_data    = load_data_q;
    assign dmem_timeout = timeout_q;

    load_align u_align (
        .rdata    (dmem_rdata),
        .off      (off_q),
        .funct3   (f3_q),
        .load_data(aligned)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            timeout_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            mbe_q       <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    addr_q      <= {alu_out_ex_mem[31:2], 2'b00};
                    off_q       <= off;
                    f3_q        <= ctrl.funct3;
                    mbe_q       <= trap ? 4'b0000 : byte_mask(ctrl.funct3[1:0], off);
                    wdata_q     <= rs2_fwd << {off, 3'b000};
                    read_q      <= ctrl.mem_read && !trap;
                    write_q     <= ctrl.mem_write && !trap;
                    load_data_q <= '0;
                    cnt_q       <= '0;
                    state_q     <= trap ? DONE : ACCESS;
                end
                // A response in the cycle the count would expire wins over the timeout.
                ACCESS: if (dmem_resp) begin
                    read_q      <= 1'b0;
                    write_q     <= 1'b0;
                    load_data_q <= read_q ? aligned : '0;
                    state_q     <= DONE;
                end else if (cnt_d == CW'(MAX_WAIT)) begin
                    read_q      <= 1'b0;
                    write_q     <= 1'b0;
                    load_data_q <= '0;
                    timeout_q   <= 1'b1;
                    state_q     <= DONE;
                end else begin
                    cnt_q <= cnt_d;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// tb_stage_memory: directed checks of the memory stage handshake, alignment, timeout and reset.
module tb_stage_memory;
    import rv32i_types::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    rv32i_control_word ctrl;
    logic [31:0]       alu_out_ex_mem, rs2_fwd, dmem_rdata;
    logic              dmem_resp;
    logic              dmem_read, dmem_write, mem_stall, load_valid, dmem_timeout;
    logic [31:0]       dmem_address, dmem_wdata, load_data;
    logic [3:0]        dmem_mbe;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic              misaligned;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    stage_memory #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ctrl(ctrl),
        .alu_out_ex_mem(alu_out_ex_mem), .rs2_fwd(rs2_fwd),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .mem_stall(mem_stall),
        .load_data(load_data), .load_valid(load_valid), .dmem_timeout(dmem_timeout)
`ifdef DMEM_MISALIGN_TRAP_EN
        , .misaligned(misaligned)
`endif
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_op(input logic ev, input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        ex_valid = ev;
        ctrl.mem_read = rd;
        ctrl.mem_write = wr;
        ctrl.funct3 = f3;
        alu_out_ex_mem = a;
        rs2_fwd = d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        dmem_resp = 1'b0;
        dmem_rdata = 32'h0;
        set_op(1, 1, 0, LW, 32'h100, 0);
        tick();
        tick(); #1;
        total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h want=0", mem_stall); end
        total++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%0h%0h want=00", dmem_read, dmem_write); end
        total++; if (dmem_mbe !== 4'h0 || dmem_address !== 32'h0 || dmem_wdata !== 32'h0) begin bad++; $display("FAIL rst_req got=%0h/%0h/%0h want=0/0/0", dmem_mbe, dmem_address, dmem_wdata); end
        total++; if (load_valid !== 1'b0 || load_data !== 32'h0 || dmem_timeout !== 1'b0) begin bad++; $display("FAIL rst_out got=%0h/%0h/%0h want=0/0/0", load_valid, load_data, dmem_timeout); end
        tick();
        rst = 1'b1;
        set_op(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_nonmem();
        tick(); set_op(1, 0, 0, LW, 32'h40, 32'h5); #1;
        total++; if (mem_stall !== 1'b0 || load_valid !== 1'b0) begin bad++; $display("FAIL nonmem got=%0h/%0h want=0/0", mem_stall, load_valid); end
        tick(); #1;
        total++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0 || load_valid !== 1'b0) begin bad++; $display("FAIL nonmem_next got=%0h%0h%0h want=000", dmem_read, dmem_write, load_valid); end
        set_op(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_lw();
        tick(); set_op(1, 1, 0, LW, 32'h100, 0); dmem_rdata = 32'hDEADBEEF; #1;
        total++; if (mem_stall !== 1'b1 || dmem_read !== 1'b0 || load_valid !== 1'b0) begin bad++; $display("FAIL lw_accept got=%0h%0h%0h want=100", mem_stall, dmem_read, load_valid); end
        tick(); dmem_resp = 1'b1; #1;
        total++; if (dmem_read !== 1'b1 || dmem_write !== 1'b0 || mem_stall !== 1'b1) begin bad++; $display("FAIL lw_access got=%0h%0h%0h want=101", dmem_read, dmem_write, mem_stall); end
        total++; if (dmem_address !== 32'h100 || dmem_mbe !== 4'hF) begin bad++; $display("FAIL lw_addr got=%0h/%0h want=100/f", dmem_address, dmem_mbe); end
        tick(); dmem_resp = 1'b0; #1;
        total++; if (load_valid !== 1'b1 || load_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_done got=%0h/%0h want=1/deadbeef", load_valid, load_data); end
        total++; if (mem_stall !== 1'b0 || dmem_read !== 1'b0) begin bad++; $display("FAIL lw_release got=%0h%0h want=00", mem_stall, dmem_read); end
        tick(); set_op(0, 0, 0, 0, 0, 0); #1;
        total++; if (load_valid !== 1'b0 || mem_stall !== 1'b0) begin bad++; $display("FAIL lw_idle got=%0h%0h want=00", load_valid, mem_stall); end
    endtask

    task automatic test_byte_loads();
        logic [2:0] f3s [2] = '{LB, LBU};
        logic [31:0] want [2] = '{32'hFFFFFF80, 32'h00000080};
        for (int i = 0; i < 2; i++) begin
            tick(); set_op(1, 1, 0, f3s[i], 32'h103, 0); dmem_rdata = 32'h80FFFFFF;
            tick(); dmem_resp = 1'b1; #1;
            total++; if (dmem_address !== 32'h100 || dmem_mbe !== 4'b1000) begin bad++; $display("FAIL byte_req%0d got=%0h/%0h want=100/8", i, dmem_address, dmem_mbe); end
            tick(); dmem_resp = 1'b0; #1;
            total++; if (load_data !== want[i] || load_valid !== 1'b1) begin bad++; $display("FAIL byte_load%0d got=%0h/%0h want=%0h/1", i, load_data, load_valid, want[i]); end
            tick(); set_op(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_sh_wait();
        tick(); set_op(1, 0, 1, SH, 32'h202, 32'h0000ABCD); dmem_rdata = 32'h11111111;
        for (int i = 0; i < 4; i++) begin
            tick(); dmem_resp = (i == 3); #1;
            total++; if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || mem_stall !== 1'b1) begin bad++; $display("FAIL sh_hold%0d got=%0h%0h%0h want=101", i, dmem_write, dmem_read, mem_stall); end
        end
        total++; if (dmem_address !== 32'h200 || dmem_mbe !== 4'b1100 || dmem_wdata !== 32'hABCD0000) begin bad++; $display("FAIL sh_req got=%0h/%0h/%0h want=200/c/abcd0000", dmem_address, dmem_mbe, dmem_wdata); end
        tick(); dmem_resp = 1'b0; #1;
        total++; if (dmem_write !== 1'b0 || load_valid !== 1'b1 || load_data !== 32'h0) begin bad++; $display("FAIL sh_done got=%0h/%0h/%0h want=0/1/0", dmem_write, load_valid, load_data); end
        total++; if (dmem_timeout !== 1'b0) begin bad++; $display("FAIL sh_resp_wins got=%0h want=0", dmem_timeout); end
        tick(); set_op(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_stores();
        logic [2:0] f3s [3] = '{SB, SW, SH};
        logic [31:0] addrs [3] = '{32'h201, 32'h204, 32'h103};
        logic [3:0] mbes [3] = '{4'b0010, 4'b1111, 4'b1000};
        logic [31:0] wds [3] = '{32'h0000EE00, 32'h12345678, 32'hCD000000};
        logic [31:0] rs [3] = '{32'h000000EE, 32'h12345678, 32'h0000ABCD};
        for (int i = 0; i < 3; i++) begin
            tick(); set_op(1, 0, 1, f3s[i], addrs[i], rs[i]);
            tick(); dmem_resp = 1'b1; #1;
            total++; if (dmem_mbe !== mbes[i] || dmem_wdata !== wds[i] || dmem_address !== {addrs[i][31:2], 2'b00}) begin bad++; $display("FAIL store%0d got=%0h/%0h/%0h want=%0h/%0h/%0h", i, dmem_mbe, dmem_wdata, dmem_address, mbes[i], wds[i], {addrs[i][31:2], 2'b00}); end
            tick(); dmem_resp = 1'b0;
            tick(); set_op(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_timeout();
        tick(); set_op(1, 1, 0, LW, 32'h300, 0); dmem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            total++; if (dmem_read !== 1'b1 || dmem_timeout !== 1'b0) begin bad++; $display("FAIL to_wait%0d got=%0h%0h want=10", i, dmem_read, dmem_timeout); end
        end
        tick(); #1;
        total++; if (dmem_timeout !== 1'b1 || dmem_read !== 1'b0 || load_valid !== 1'b1 || load_data !== 32'h0) begin bad++; $display("FAIL to_done got=%0h/%0h/%0h/%0h want=1/0/1/0", dmem_timeout, dmem_read, load_valid, load_data); end
        tick(); set_op(0, 0, 0, 0, 0, 0); dmem_resp = 1'b1;
        tick(); dmem_resp = 1'b0; #1;
        total++; if (load_valid !== 1'b0 || dmem_read !== 1'b0) begin bad++; $display("FAIL stray_resp got=%0h%0h want=00", load_valid, dmem_read); end
        tick(); set_op(1, 1, 0, LW, 32'h104, 0); dmem_rdata = 32'h12345678;
        tick(); dmem_resp = 1'b1;
        tick(); dmem_resp = 1'b0; #1;
        total++; if (load_data !== 32'h12345678 || load_valid !== 1'b1 || dmem_timeout !== 1'b1) begin bad++; $display("FAIL after_to got=%0h/%0h/%0h want=12345678/1/1", load_data, load_valid, dmem_timeout); end
        tick(); set_op(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        tick(); set_op(1, 1, 0, LW, 32'h400, 0); dmem_rdata = 32'hCAFEF00D;
        tick();
        tick(); rst = 1'b0; #1;
        total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%0h want=0", mem_stall); end
        tick(); rst = 1'b1; set_op(0, 0, 0, 0, 0, 0); dmem_resp = 1'b1; #1;
        total++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0 || mem_stall !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%0h%0h%0h want=000", dmem_read, dmem_write, mem_stall); end
        total++; if (dmem_timeout !== 1'b0 || dmem_address !== 32'h0 || load_data !== 32'h0) begin bad++; $display("FAIL midrst_clear got=%0h/%0h/%0h want=0/0/0", dmem_timeout, dmem_address, load_data); end
        tick(); dmem_resp = 1'b0; #1;
        total++; if (load_valid !== 1'b0) begin bad++; $display("FAIL late_resp got=%0h want=0", load_valid); end
    endtask

`ifdef DMEM_MISALIGN_TRAP_EN
    task automatic test_misalign_trap();
        tick(); set_op(1, 1, 0, LW, 32'h101, 0); dmem_rdata = 32'hFFFFFFFF; #1;
        total++; if (misaligned !== 1'b1 || mem_stall !== 1'b0) begin bad++; $display("FAIL trap_pulse got=%0h%0h want=10", misaligned, mem_stall); end
        tick(); #1;
        total++; if (misaligned !== 1'b0 || dmem_read !== 1'b0 || load_valid !== 1'b1 || load_data !== 32'h0) begin bad++; $display("FAIL trap_done got=%0h/%0h/%0h/%0h want=0/0/1/0", misaligned, dmem_read, load_valid, load_data); end
        tick(); set_op(0, 0, 0, 0, 0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_nonmem();
        test_lw();
        test_byte_loads();
        test_sh_wait();
`ifdef DMEM_MISALIGN_TRAP_EN
        test_misalign_trap();
`else
        test_stores();
`endif
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
